// File: rtl/misr_pkg.sv
// Shared MISR definitions: FSM state encoding, default feedback taps and the
// single-step compaction function used by both the datapath and its models.
package misr_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } misr_state_t;

  localparam logic [MAX_W-1:0] POLY_W4  = 64'h3;
  localparam logic [MAX_W-1:0] POLY_W8  = 64'h1D;
  localparam logic [MAX_W-1:0] POLY_W16 = 64'h100B;
  localparam logic [MAX_W-1:0] POLY_W32 = 64'h0040_0007;

  function automatic logic [MAX_W-1:0] default_poly(input int width);
    case (width)
      8:       return POLY_W8;
      16:      return POLY_W16;
      32:      return POLY_W32;
      default: return POLY_W4;
    endcase
  endfunction

  // Shift left, fold the outgoing MSB back through the taps, xor in the response.
  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] sig,
                                                 input logic [MAX_W-1:0] resp,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int width);
    logic [MAX_W-1:0] mask;
    logic             msb;
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    msb  = sig[width-1];
    return ((sig << 1) ^ (msb ? poly : '0) ^ resp) & mask;
  endfunction

endpackage

// File: rtl/misr_response_analyzer_if.sv
// Response/result bundle between the CUT-side driver and the MISR analyzer.
// resp_mask exists only when MISR_X_MASK_EN is defined.
interface misr_response_analyzer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
);
  logic             start;
  logic             resp_valid;
  logic [WIDTH-1:0] resp;
`ifdef MISR_X_MASK_EN
  logic [WIDTH-1:0] resp_mask;
`endif
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, resp_valid, resp,
`ifdef MISR_X_MASK_EN
    output resp_mask,
`endif
    input  busy, done, pass, signature, sample_cnt
  );

  modport slave (
    input  start, resp_valid, resp,
`ifdef MISR_X_MASK_EN
    input  resp_mask,
`endif
    output busy, done, pass, signature, sample_cnt
  );
endinterface

// File: rtl/misr_core.sv
// WIDTH-bit multiple-input signature register: load forces SEED, step compacts d.
// nxt exposes the would-be next value so the caller can compare it in the same edge.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'h3),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             CP,
  input  logic             CD,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  assign nxt = WIDTH'(misr_step(MAX_W'(q), MAX_W'(d), MAX_W'(POLY), WIDTH));

  always_ff @(posedge CP or posedge CD) begin
    if (CD)        q <= SEED;
    else if (load) q <= SEED;
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/misr_response_analyzer.sv
// MISR response analyzer: run FSM, sample counter and golden compare around misr_core.
// Optional MISR_X_MASK_EN adds resp_mask to zero unknown response bits before compaction.
//
// state   | meaning
// IDLE    | waiting for start, signature/count at reset values
// COMPACT | accepting resp_valid samples until N_SAMPLES taken
// DONE    | result held, pass valid, start re-arms a new run
module misr_response_analyzer
  import misr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int               N_SAMPLES = 2,
  parameter logic [WIDTH-1:0] GOLDEN    = WIDTH'(4'h2),
  localparam int              CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input logic                      CP,
  input logic                      CD,
  misr_response_analyzer_if.slave  bus
);

  misr_state_t      state;
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] resp_eff, sig, sig_nxt;
  logic             load, step, last;

`ifdef MISR_X_MASK_EN
  assign resp_eff = bus.resp & ~bus.resp_mask;
`else
  assign resp_eff = bus.resp;
`endif

  assign load = bus.start && (state != COMPACT);
  assign step = (state == COMPACT) && bus.resp_valid;
  assign last = (cnt_q == CNT_W'(N_SAMPLES - 1));

  misr_core #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_core (
    .CP   (CP),
    .CD   (CD),
    .load (load),
    .step (step),
    .d    (resp_eff),
    .q    (sig),
    .nxt  (sig_nxt)
  );

  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= COMPACT;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            cnt_q  <= '0;
          end
        end
        COMPACT: begin
          if (bus.resp_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (sig_nxt == GOLDEN);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.signature  = sig;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Directed self-checking bench for misr_response_analyzer (default parameters).
// Define MISR_X_MASK_EN to also exercise the response mask.
module tb_misr_response_analyzer;

  logic CP = 1'b0;
  logic CD = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 CP = ~CP;

  misr_response_analyzer_if #(.WIDTH(4), .CNT_W(2)) bus ();

  misr_response_analyzer dut (
    .CP  (CP),
    .CD  (CD),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic d, input logic p,
                         input logic [3:0] s, input logic [1:0] c);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
    chk({tag, ".pass"}, 32'(bus.pass), 32'(p));
    chk({tag, ".sig"},  32'(bus.signature), 32'(s));
    chk({tag, ".cnt"},  32'(bus.sample_cnt), 32'(c));
  endtask

  task automatic sample(input logic [3:0] r);
    bus.resp_valid = 1'b1;
    bus.resp       = r;
    tick();
    bus.resp_valid = 1'b0;
    bus.resp       = 4'h0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp       = 4'h0;
`ifdef MISR_X_MASK_EN
    bus.resp_mask  = 4'h0;
`endif
    #2;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    tick();
    CD = 1'b0;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);

    // golden run
    do_start();
    chk_all("start", 1'b1, 1'b0, 1'b0, 4'h0, 2'd0);
    sample(4'h8);
    chk_all("g.s1", 1'b1, 1'b0, 1'b0, 4'h8, 2'd1);
    sample(4'h1);
    chk_all("g.s2", 1'b0, 1'b1, 1'b1, 4'h2, 2'd2);
    bus.resp_valid = 1'b1;
    bus.resp       = 4'hF;
    tick();
    chk_all("g.hold", 1'b0, 1'b1, 1'b1, 4'h2, 2'd2);

    // restart from DONE with resp_valid in the start cycle (must be ignored)
    bus.start = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.resp_valid = 1'b0;
    chk_all("restart", 1'b1, 1'b0, 1'b0, 4'h0, 2'd0);
    sample(4'h8);
    tick();
    tick();
    chk_all("gap", 1'b1, 1'b0, 1'b0, 4'h8, 2'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_all("start_in_compact", 1'b1, 1'b0, 1'b0, 4'h8, 2'd1);
    sample(4'h1);
    chk_all("gap.s2", 1'b0, 1'b1, 1'b1, 4'h2, 2'd2);

    // failing run
    do_start();
    sample(4'h8);
    sample(4'h0);
    chk_all("fail_run", 1'b0, 1'b1, 1'b0, 4'h3, 2'd2);

    // asynchronous abort mid-run
    do_start();
    sample(4'h8);
    #2;
    CD = 1'b1;
    #1;
    chk_all("abort", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    tick();
    CD = 1'b0;
    bus.resp_valid = 1'b1;
    bus.resp       = 4'h5;
    tick();
    tick();
    bus.resp_valid = 1'b0;
    chk_all("post_abort", 1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    do_start();
    sample(4'h8);
    sample(4'h1);
    chk_all("rerun", 1'b0, 1'b1, 1'b1, 4'h2, 2'd2);

`ifdef MISR_X_MASK_EN
    bus.resp_mask = 4'h1;
    do_start();
    sample(4'h8);
    sample(4'h1);
    chk_all("mask", 1'b0, 1'b1, 1'b0, 4'h3, 2'd2);
    bus.resp_mask = 4'h0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
